// File: rtl/divisor_postproceso.sv
`default_nettype none
// ============================================================================
// Module   : divisor_postproceso
// Purpose  : Output stage of the pipelined restoring divider. Applies the
//            operand signs to the magnitude quotient and remainder using
//            truncating-division rules. Flags division by zero. Buffers
//            the results in a small FIFO with a Valid/Ready handshake.
//            The upstream iteration pipeline cannot stall. A result that
//            arrives while the FIFO is full, with no pop on that edge, is
//            dropped and sets a sticky overflow flag.
// Ports    : CLK            - clock, rising edge
//            RSTa           - asynchronous reset, active low
//            Done           - last-stage result valid (one pulse/division)
//            Q/ACCU/M       - quotient/remainder/divisor magnitudes
//            SignNum/SignDen- dividend/divisor signs (1 = negative)
//            Ready          - consumer accepts the head entry
//            Valid          - FIFO not empty, head entry on Coc/Res/DivCero
//            Coc/Res        - signed quotient/remainder (two's complement)
//            DivCero        - head entry was a division by zero
//            Cuenta         - FIFO occupancy, 0..PROF
//            Lleno          - FIFO full
//            Desbordamiento - sticky: a result was dropped (FIFO full)
// Revision : 1.0 - initial release
// ============================================================================
module divisor_postproceso #(
    parameter int tamanyo = 32,
    parameter int PROF    = 4
) (
    input  logic                     CLK,
    input  logic                     RSTa,
    input  logic                     Done,
    input  logic [tamanyo-1:0]       Q,
    input  logic [tamanyo-1:0]       ACCU,
    input  logic [tamanyo-1:0]       M,
    input  logic                     SignNum,
    input  logic                     SignDen,
    input  logic                     Ready,
    output logic                     Valid,
    output logic [tamanyo-1:0]       Coc,
    output logic [tamanyo-1:0]       Res,
    output logic                     DivCero,
    output logic [$clog2(PROF):0]    Cuenta,
    output logic                     Lleno,
    output logic                     Desbordamiento
);

    localparam int c_PTR_W = $clog2(PROF);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(PROF);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [tamanyo-1:0] c_ZERO     = '0;
    localparam logic [tamanyo-1:0] c_ONES     = '1;

    // FIFO storage and control
    logic [tamanyo-1:0] r_mem_coc [PROF];
    logic [tamanyo-1:0] r_mem_res [PROF];
    logic               r_mem_dz  [PROF];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf;

    // Sign correction on the incoming result
    logic [tamanyo-1:0] w_coc_n;
    logic [tamanyo-1:0] w_res_n;
    logic               w_dz_n;

    logic               w_valid;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    always_comb begin
        w_dz_n  = (M == c_ZERO);
        w_res_n = SignNum ? (c_ZERO - ACCU) : ACCU;
        // Division by zero forces an all-ones quotient. The remainder
        // still follows the dividend sign, so it equals the signed dividend.
        if (w_dz_n) begin
            w_coc_n = c_ONES;
        end else begin
            w_coc_n = (SignNum ^ SignDen) ? (c_ZERO - Q) : Q;
        end
    end

    // Handshake decode. A pop is only possible with a stored entry, so an
    // empty FIFO with Done and Ready together performs a push only. A full
    // FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        w_valid = (r_count != '0);
        w_full  = (r_count == c_CNT_FULL);
        w_pop   = w_valid & Ready;
        w_push  = Done & (~w_full | w_pop);
        w_drop  = Done & w_full & ~w_pop;
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < PROF; i++) begin
                r_mem_coc[i] <= '0;
                r_mem_res[i] <= '0;
                r_mem_dz[i]  <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mem_coc[r_wr_ptr] <= w_coc_n;
                r_mem_res[r_wr_ptr] <= w_res_n;
                r_mem_dz[r_wr_ptr]  <= w_dz_n;
                r_wr_ptr            <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Output data is forced to zero while the FIFO is empty, so stale
    // entries are never visible to the consumer.
    always_comb begin
        Valid          = w_valid;
        Coc            = w_valid ? r_mem_coc[r_rd_ptr] : c_ZERO;
        Res            = w_valid ? r_mem_res[r_rd_ptr] : c_ZERO;
        DivCero        = w_valid ? r_mem_dz[r_rd_ptr]  : 1'b0;
        Cuenta         = r_count;
        Lleno          = w_full;
        Desbordamiento = r_ovf;
    end

endmodule
`default_nettype wire
